// File: rtl/sap_control_seq.sv
// sap_control_seq: SAP-1 style control sequencer.
// The T-state advances on the rising edge of clk; the control word is
// registered on the falling edge so it is stable around the next rising edge.
// Optional macro SAP_STEP_EN adds a 'step' input for single-step operation:
// at the end of each instruction the sequencer parks in IDLE until step=1.
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | after reset (or between steps), no control active
// T0..T2 | fetch: address out, PC increment, load IR
// T3..T5 | execute, length depends on the latched opcode
// HALT   | HLT executed, parked until reset

module sap_control_seq #(
  parameter int OPW = 4,
  parameter int CW  = 13,
  parameter int NT  = 6
) (
  input  logic           clk,
  input  logic           clr,
`ifdef SAP_STEP_EN
  input  logic           step,
`endif
  input  logic [OPW-1:0] opcode,
  input  logic           zflag,
  output logic [CW-1:0]  cntrlcodes,
  output logic [NT-1:0]  tstate,
  output logic           halted,
  output logic           instr_done
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_HALT = 4'd7
  } state_t;

  localparam logic [OPW-1:0] OP_LDA = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_JMP = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_OUT = OPW'(4'hE);
  localparam logic [OPW-1:0] OP_HLT = OPW'(4'hF);

  localparam logic [CW-1:0] W_FETCH0 = CW'(13'h0600);
  localparam logic [CW-1:0] W_FETCH1 = CW'(13'h0800);
  localparam logic [CW-1:0] W_FETCH2 = CW'(13'h0180);
  localparam logic [CW-1:0] W_ADDR   = CW'(13'h0240);
  localparam logic [CW-1:0] W_LDA4   = CW'(13'h0120);
  localparam logic [CW-1:0] W_LDB4   = CW'(13'h0102);
  localparam logic [CW-1:0] W_ADD5   = CW'(13'h0024);
  localparam logic [CW-1:0] W_SUB5   = CW'(13'h002C);
  localparam logic [CW-1:0] W_JUMP   = CW'(13'h1040);
  localparam logic [CW-1:0] W_OUT    = CW'(13'h0011);

  state_t         state_q, state_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  logic [NT-1:0]  tstate_q, tstate_d;
  logic           halted_q, halted_d;
  logic           done_q, done_d;
  logic [CW-1:0]  cntrl_q, cntrl_d;
  logic           step_go;
  state_t         end_target;

  // Whether the sequencer may leave IDLE / chain into the next fetch.
  always_comb begin
`ifdef SAP_STEP_EN
    step_go = step;
`else
    step_go = 1'b1;
`endif
    end_target = step_go ? S_T0 : S_IDLE;
  end

  // Next state, opcode latch, and registered-output precomputation.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    if (state_q == S_T2) opcode_d = opcode;

    case (state_q)
      S_IDLE: state_d = step_go ? S_T0 : S_IDLE;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (opcode_q == OP_LDA || opcode_q == OP_ADD || opcode_q == OP_SUB)
          state_d = S_T4;
        else if (opcode_q == OP_HLT)
          state_d = S_HALT;
        else
          state_d = end_target;
      end
      S_T4: begin
        if (opcode_q == OP_ADD || opcode_q == OP_SUB) state_d = S_T5;
        else                                          state_d = end_target;
      end
      S_T5:   state_d = end_target;
      S_HALT: state_d = S_HALT;
      default: state_d = S_T0;
    endcase

    // opcode_d is the opcode that will be held while state_d is active,
    // so the end-of-instruction flag can be registered with the state.
    done_d = 1'b0;
    case (state_d)
      S_T3:    done_d = !(opcode_d == OP_LDA || opcode_d == OP_ADD || opcode_d == OP_SUB);
      S_T4:    done_d = (opcode_d == OP_LDA);
      S_T5:    done_d = 1'b1;
      default: done_d = 1'b0;
    endcase

    tstate_d = '0;
    case (state_d)
      S_T0:    tstate_d = NT'(1) << 0;
      S_T1:    tstate_d = NT'(1) << 1;
      S_T2:    tstate_d = NT'(1) << 2;
      S_T3:    tstate_d = NT'(1) << 3;
      S_T4:    tstate_d = NT'(1) << 4;
      S_T5:    tstate_d = NT'(1) << 5;
      default: tstate_d = '0;
    endcase

    halted_d = (state_d == S_HALT);
  end

  // Rising-edge sequencer state with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      tstate_q <= '0;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      tstate_q <= tstate_d;
      halted_q <= halted_d;
      done_q   <= done_d;
    end
  end

  // Control word for the current T-state and latched opcode.
  always_comb begin
    cntrl_d = '0;
    case (state_q)
      S_T0: cntrl_d = W_FETCH0;
      S_T1: cntrl_d = W_FETCH1;
      S_T2: cntrl_d = W_FETCH2;
      S_T3: begin
        case (opcode_q)
          OP_LDA, OP_ADD, OP_SUB: cntrl_d = W_ADDR;
          OP_JMP:                 cntrl_d = W_JUMP;
          OP_JZ:                  cntrl_d = zflag ? W_JUMP : '0;
          OP_OUT:                 cntrl_d = W_OUT;
          default:                cntrl_d = '0;
        endcase
      end
      S_T4: begin
        case (opcode_q)
          OP_LDA:         cntrl_d = W_LDA4;
          OP_ADD, OP_SUB: cntrl_d = W_LDB4;
          default:        cntrl_d = '0;
        endcase
      end
      S_T5: begin
        case (opcode_q)
          OP_ADD:  cntrl_d = W_ADD5;
          OP_SUB:  cntrl_d = W_SUB5;
          default: cntrl_d = '0;
        endcase
      end
      default: cntrl_d = '0;
    endcase
  end

  // Falling-edge control word register; clear wins over any pending word.
  always_ff @(negedge clk) begin
    if (!clr) cntrl_q <= '0;
    else      cntrl_q <= cntrl_d;
  end

  assign cntrlcodes = cntrl_q;
  assign tstate     = tstate_q;
  assign halted     = halted_q;
  assign instr_done = done_q;

endmodule

// File: tb/tb_sap_control_seq.sv
// Scoreboard bench for sap_control_seq. Each stimulus cycle pushes the
// expected outputs; a monitor pops and compares just after every falling edge.
module tb_sap_control_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        step_in;
  logic [3:0]  opcode;
  logic        zflag;
  logic [12:0] cntrlcodes;
  logic [5:0]  tstate;
  logic        halted;
  logic        instr_done;

  typedef struct {
    logic [5:0]  t;
    logic [12:0] c;
    logic        h;
    logic        d;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  sap_control_seq #(.OPW(4), .CW(13), .NT(6)) dut (
    .clk        (clk),
    .clr        (clr),
`ifdef SAP_STEP_EN
    .step       (step_in),
`endif
    .opcode     (opcode),
    .zflag      (zflag),
    .cntrlcodes (cntrlcodes),
    .tstate     (tstate),
    .halted     (halted),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  // Drive inputs for the next rising/falling edge pair and queue what
  // should be visible just after that falling edge.
  task automatic cyc(input logic c, input logic st, input logic [3:0] op,
                     input logic z, input logic [5:0] et, input logic [12:0] ec,
                     input logic eh, input logic ed, input string nm);
    exp_t e;
    @(negedge clk);
    #2;
    clr     = c;
    step_in = st;
    opcode  = op;
    zflag   = z;
    e.t = et; e.c = ec; e.h = eh; e.d = ed; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic fetch(input logic [3:0] op, input logic z, input string nm);
    cyc(1, 1, op, z, 6'h01, 13'h0600, 0, 0, {nm, "_t0"});
    cyc(1, 1, op, z, 6'h02, 13'h0800, 0, 0, {nm, "_t1"});
    cyc(1, 1, op, z, 6'h04, 13'h0180, 0, 0, {nm, "_t2"});
  endtask

  // Monitor: compare the DUT outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (tstate !== e.t || cntrlcodes !== e.c || halted !== e.h || instr_done !== e.d) begin
          tests_failed++;
          $display("FAIL %s: got tstate=%h cntrl=%h halted=%b done=%b, expected tstate=%h cntrl=%h halted=%b done=%b",
                   e.name, tstate, cntrlcodes, halted, instr_done, e.t, e.c, e.h, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0; step_in = 1'b1; opcode = 4'h0; zflag = 1'b0;
    repeat (2) @(negedge clk);

    cyc(0, 1, 4'h0, 0, 6'h00, 13'h0000, 0, 0, "reset");

    // LDA
    fetch(4'h0, 0, "lda");
    cyc(1, 1, 4'h0, 0, 6'h08, 13'h0240, 0, 0, "lda_t3");
    cyc(1, 1, 4'h0, 0, 6'h10, 13'h0120, 0, 1, "lda_t4");
    // ADD
    fetch(4'h1, 0, "add");
    cyc(1, 1, 4'h1, 0, 6'h08, 13'h0240, 0, 0, "add_t3");
    cyc(1, 1, 4'h1, 0, 6'h10, 13'h0102, 0, 0, "add_t4");
    cyc(1, 1, 4'h1, 0, 6'h20, 13'h0024, 0, 1, "add_t5");
    // SUB
    fetch(4'h2, 0, "sub");
    cyc(1, 1, 4'h2, 0, 6'h08, 13'h0240, 0, 0, "sub_t3");
    cyc(1, 1, 4'h2, 0, 6'h10, 13'h0102, 0, 0, "sub_t4");
    cyc(1, 1, 4'h2, 0, 6'h20, 13'h002C, 0, 1, "sub_t5");
    // JZ taken / not taken
    fetch(4'h4, 1, "jz1");
    cyc(1, 1, 4'h4, 1, 6'h08, 13'h1040, 0, 1, "jz1_t3");
    fetch(4'h4, 0, "jz0");
    cyc(1, 1, 4'h4, 0, 6'h08, 13'h0000, 0, 1, "jz0_t3");
    // OUT, NOP, JMP
    fetch(4'hE, 0, "out");
    cyc(1, 1, 4'hE, 0, 6'h08, 13'h0011, 0, 1, "out_t3");
    fetch(4'h5, 0, "nop");
    cyc(1, 1, 4'h5, 0, 6'h08, 13'h0000, 0, 1, "nop_t3");
    fetch(4'h3, 1, "jmp");
    cyc(1, 1, 4'h3, 1, 6'h08, 13'h1040, 0, 1, "jmp_t3");
    // ADD aborted by clear during T4: no T5 word ever appears
    fetch(4'h1, 0, "abt");
    cyc(1, 1, 4'h1, 0, 6'h08, 13'h0240, 0, 0, "abt_t3");
    cyc(1, 1, 4'h1, 0, 6'h10, 13'h0102, 0, 0, "abt_t4");
    cyc(0, 1, 4'h1, 0, 6'h00, 13'h0000, 0, 0, "abt_clr");
    cyc(1, 1, 4'h1, 0, 6'h01, 13'h0600, 0, 0, "abt_t0");
    cyc(1, 1, 4'h1, 0, 6'h02, 13'h0800, 0, 0, "abt_t1");
    cyc(1, 1, 4'h1, 0, 6'h04, 13'h0180, 0, 0, "abt_t2");
    // HLT, held 20 cycles, then released by clear
    cyc(1, 1, 4'hF, 0, 6'h08, 13'h0000, 0, 1, "hlt_t3");
    for (int i = 0; i < 20; i++)
      cyc(1, 1, 4'h1, 1, 6'h00, 13'h0000, 1, 0, $sformatf("halt_%0d", i));
    cyc(0, 1, 4'h1, 0, 6'h00, 13'h0000, 0, 0, "halt_clr");
    cyc(1, 1, 4'h1, 0, 6'h01, 13'h0600, 0, 0, "post_t0");

`ifdef SAP_STEP_EN
    cyc(1, 1, 4'hE, 0, 6'h02, 13'h0800, 0, 0, "stp_t1");
    cyc(1, 1, 4'hE, 0, 6'h04, 13'h0180, 0, 0, "stp_t2");
    cyc(1, 1, 4'hE, 0, 6'h08, 13'h0011, 0, 1, "stp_t3");
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 4'hE, 0, 6'h00, 13'h0000, 0, 0, $sformatf("stp_idle_%0d", i));
    cyc(1, 1, 4'hE, 0, 6'h01, 13'h0600, 0, 0, "stp_go");
    cyc(1, 0, 4'hE, 0, 6'h02, 13'h0800, 0, 0, "stp_t1b");
    cyc(1, 0, 4'hE, 0, 6'h04, 13'h0180, 0, 0, "stp_t2b");
    cyc(1, 0, 4'hE, 0, 6'h08, 13'h0011, 0, 1, "stp_t3b");
    cyc(1, 0, 4'hE, 0, 6'h00, 13'h0000, 0, 0, "stp_idle_b");
`endif

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations never checked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
